data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Data-side RAM that sits directly downstream of the core's data port. It consumes the core's rw, address, write data and byte strobe, and returns read data.
- Provides word-addressed synchronous storage with byte-lane writes and range/strobe checking with a sticky error.
- An optional small MMIO window provides a cycle counter, a scratch register and a tohost/halt register for simulation and bring-up.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, minimum 4.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be DEPTH_WORDS*4 aligned.
- MMIO_BASE, 32'hFFFF_0000, byte base of the MMIO window; only used with DATA_MEM_MMIO_EN.

Ports:
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_data_rw  in  1  1 = write this cycle, 0 = read only.
- i_data_address  in  32  byte address.
- i_data  in  32  write data from core.
- i_data_rw_strobe  in  4  byte enables; bit n selects bits [8n+7:8n].
- o_data  out  32  registered read data.
- o_error  out  1  sticky access fault.
- o_error_address  out  32  address of first fault.
- o_halt  out  1  set by a tohost write; MMIO builds only, else tied 0.
- o_tohost  out  32  value of the tohost write; MMIO builds only, else tied 0.

Behaviour:
- Reset (i_reset==0 at edge): o_data=0, o_error=0, o_error_address=0, o_halt=0, o_tohost=0, cycle counter=0, scratch=0. RAM contents are not cleared.
- Address decode:
  - word index = i_data_address[log2(DEPTH_WORDS)+1:2], offset from ADDR_BASE.
  - RAM hit: ADDR_BASE <= addr < ADDR_BASE + DEPTH_WORDS*4.
  - Address bits [1:0] are ignored; the strobe selects the lanes.
- Read:
  - Every cycle, o_data <= word at the current address (RAM or MMIO). Latency is exactly 1 cycle.
  - Miss (neither RAM nor MMIO) returns 32'h0.
  - Same-address read-during-write is read-first: o_data shows the pre-write word. The new value is visible on the next cycle's read.
- Write (i_data_rw==1):
  - Legal strobes are 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - A legal-strobe RAM hit updates only the enabled bytes at the edge.
  - Strobe 0000 with rw=1 is a no-op and not an error.
  - Any other strobe is illegal: no write occurs and it is a fault.
- Faults: illegal strobe on write, or rw=1 to an address that is neither RAM nor MMIO.
  - A read miss is not a fault.
  - On the first fault: o_error <= 1 and o_error_address <= i_data_address. Both hold until reset; later faults do not overwrite.
- Simultaneous fault + legal condition in the same cycle cannot occur (single port). A fault cycle performs no write anywhere.
- Reset asserted mid-write: the reset wins for registers; the RAM write in that cycle is suppressed.

Optional Feature:
- Macro: DATA_MEM_MMIO_EN.
- Defined: the MMIO window at MMIO_BASE+0x0..0xB is decoded; MMIO takes priority over RAM on overlap.
  - +0x0 CYCLE: read-only 32-bit count of cycles since reset, +1 per edge, wraps 0xFFFF_FFFF->0. A write to it is ignored and not a fault.
  - +0x4 TOHOST: a strobe-1111 write sets o_halt=1 and o_tohost=i_data. o_halt is sticky until reset. Reads return o_tohost. A partial-strobe write is a fault.
  - +0x8 SCRATCH: read/write, byte-strobed like RAM.
- Undefined: no MMIO decode; those addresses are misses (write = fault). o_halt and o_tohost are constant 0. No counter logic.

Test Plan:
- Reset with i_reset=0 for 2 cycles, then release -> all outputs 0. Read of addr 0x0 after a prior write still returns the written data (RAM not cleared).
- Write 0xDEADBEEF strobe 1111 to 0x10, then write 0x000000AA strobe 0001 to 0x10, then read 0x10 -> o_data=0xDEADBEAA one cycle after the read address.
- Write 0x11111111 to 0x20 while reading 0x20 in the same cycle -> o_data shows the old word. The next cycle shows 0x11111111.
- Write strobe 0101 to 0x30, then write 0xFFFF_FFFF to 0x0000_1000 with DEPTH_WORDS=1024 -> o_error=1 and o_error_address=0x30 (first fault kept). The word at 0x30 is unchanged.
- Read address 0x0000_2000 with rw=0 -> o_data=0, o_error stays 0.
- DATA_MEM_MMIO_EN: read CYCLE at two reads 5 cycles apart -> difference 5. Write 0x1 strobe 1111 to MMIO_BASE+4 -> o_halt=1, o_tohost=1 next cycle.

Source files
------------

// File: rtl/data_memory.sv
// Data-side RAM behind the core data port: word-addressed, byte-strobed, read-first, sticky fault capture.
// Define DATA_MEM_MMIO_EN to decode the CYCLE / TOHOST / SCRATCH window at MMIO_BASE.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_data_rw,
  input  logic [31:0] i_data_address,
  input  logic [31:0] i_data,
  input  logic [3:0]  i_data_rw_strobe,
  output logic [31:0] o_data,
  output logic        o_error,
  output logic [31:0] o_error_address,
  output logic        o_halt,
  output logic [31:0] o_tohost
);

  // Interface: no handshake. One access is accepted at every rising edge
  // (rw/address/data/strobe sampled there), and o_data carries that access's
  // read word exactly one cycle later. The core never stalls this port.

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   ram_offset;
  logic [AW-1:0] ram_index;
  logic          ram_hit;
  logic          strobe_legal;
  logic          strobe_nonzero;
  logic          access_fault;
  logic          write_ok;
  logic          ram_we;
  logic [31:0]   rdata_next;

  logic          mmio_hit;
  logic          tohost_partial;
  logic [31:0]   mmio_rdata;

  // ADDR_BASE is DEPTH_WORDS*4 aligned, so the offset's index bits equal the raw address bits.
  assign ram_offset     = i_data_address - ADDR_BASE;
  assign ram_hit        = {1'b0, ram_offset} < RAM_BYTES;
  assign ram_index      = ram_offset[AW+1:2];
  assign strobe_nonzero = |i_data_rw_strobe;

  always_comb begin
    strobe_legal = 1'b0;
    case (i_data_rw_strobe)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: strobe_legal = 1'b1;
      default:                   strobe_legal = 1'b0;
    endcase
  end

`ifdef DATA_MEM_MMIO_EN
  logic [31:0] mmio_offset;
  logic [31:0] cycle_cnt;
  logic [31:0] scratch_q;
  logic [31:0] tohost_q;
  logic        halt_q;
  logic        sel_tohost;
  logic        sel_scratch;

  assign mmio_offset    = i_data_address - MMIO_BASE;
  assign mmio_hit       = mmio_offset < 32'd12;
  assign sel_tohost     = mmio_hit && (mmio_offset[3:2] == 2'd1);
  assign sel_scratch    = mmio_hit && (mmio_offset[3:2] == 2'd2);
  assign tohost_partial = sel_tohost && strobe_nonzero && (i_data_rw_strobe != 4'b1111);

  always_comb begin
    mmio_rdata = scratch_q;
    case (mmio_offset[3:2])
      2'd0:    mmio_rdata = cycle_cnt;
      2'd1:    mmio_rdata = tohost_q;
      default: mmio_rdata = scratch_q;
    endcase
  end

  // CYCLE ignores writes; TOHOST only takes full-word writes (partials fault upstream).
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      cycle_cnt <= 32'h0;
      scratch_q <= 32'h0;
      tohost_q  <= 32'h0;
      halt_q    <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (write_ok && sel_scratch) begin
        for (int b = 0; b < 4; b++) begin
          if (i_data_rw_strobe[b]) scratch_q[8*b +: 8] <= i_data[8*b +: 8];
        end
      end
      if (write_ok && sel_tohost) begin
        halt_q   <= 1'b1;
        tohost_q <= i_data;
      end
    end
  end

  assign o_halt   = halt_q;
  assign o_tohost = tohost_q;
`else
  logic unused_mmio_base;

  assign mmio_hit         = 1'b0;
  assign tohost_partial   = 1'b0;
  assign mmio_rdata       = 32'h0;
  assign o_halt           = 1'b0;
  assign o_tohost         = 32'h0;
  assign unused_mmio_base = ^MMIO_BASE;
`endif

  always_comb begin
    access_fault = 1'b0;
    if (i_data_rw) begin
      if (strobe_nonzero && !strobe_legal) access_fault = 1'b1;
      else if (!mmio_hit && !ram_hit)      access_fault = 1'b1;
      else if (tohost_partial)             access_fault = 1'b1;
    end
  end

  assign write_ok = i_data_rw && strobe_nonzero && !access_fault;
  // MMIO shadows RAM on overlap; a reset edge also blocks the array write.
  assign ram_we   = write_ok && ram_hit && !mmio_hit && i_reset;

  always_comb begin
    rdata_next = 32'h0;
    if (mmio_hit)     rdata_next = mmio_rdata;
    else if (ram_hit) rdata_next = mem[ram_index];
  end

  always_ff @(posedge i_clock) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_data_rw_strobe[b]) mem[ram_index][8*b +: 8] <= i_data[8*b +: 8];
      end
    end
  end

  // o_data samples the array before this edge's write lands, giving read-first behaviour.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      o_data          <= 32'h0;
      o_error         <= 1'b0;
      o_error_address <= 32'h0;
    end else begin
      o_data <= rdata_next;
      if (access_fault && !o_error) begin
        o_error         <= 1'b1;
        o_error_address <= i_data_address;
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Testbench for data_memory: directed scenarios plus a randomized run against a behavioural memory model.
module tb_data_memory;

  localparam int unsigned     DEPTH_WORDS = 1024;
  localparam longint unsigned ADDR_BASE   = 64'h0000_0000;
  localparam longint unsigned MMIO_BASE   = 64'hFFFF_0000;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_data_rw;
  logic [31:0] i_data_address;
  logic [31:0] i_data;
  logic [3:0]  i_data_rw_strobe;
  logic [31:0] o_data;
  logic        o_error;
  logic [31:0] o_error_address;
  logic        o_halt;
  logic [31:0] o_tohost;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [int];
  logic        ref_err;
  logic [31:0] ref_err_addr;
  logic        ref_halt;
  logic [31:0] ref_tohost;
  logic [31:0] ref_scratch;
  logic [31:0] ref_cycle;

  logic [3:0] legal_list [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

  data_memory #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_BASE   (32'(ADDR_BASE)),
    .MMIO_BASE   (32'(MMIO_BASE))
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_data_rw        (i_data_rw),
    .i_data_address   (i_data_address),
    .i_data           (i_data),
    .i_data_rw_strobe (i_data_rw_strobe),
    .o_data           (o_data),
    .o_error          (o_error),
    .o_error_address  (o_error_address),
    .o_halt           (o_halt),
    .o_tohost         (o_tohost)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clock = ~i_clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic do_reset(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    i_reset          = 1'b0;
    i_data_rw        = rw;
    i_data_address   = addr;
    i_data           = data;
    i_data_rw_strobe = strb;
    repeat (2) @(posedge i_clock);
    #1;
    i_reset          = 1'b1;
    i_data_rw        = 1'b0;
    i_data_rw_strobe = 4'h0;
    ref_err      = 1'b0;
    ref_err_addr = 32'h0;
    ref_halt     = 1'b0;
    ref_tohost   = 32'h0;
    ref_scratch  = 32'h0;
    ref_cycle    = 32'h0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic model_access(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
    longint unsigned a;
    longint unsigned moff;
    bit              ram;
    bit              mmio;
    bit              legal;
    bit              fault;
    int              widx;
    logic [31:0]     rd;
    a    = 64'(addr);
    ram  = (a >= ADDR_BASE) && (a < ADDR_BASE + 64'(DEPTH_WORDS) * 4);
    widx = int'((a - ADDR_BASE) / 4);
    mmio = 1'b0;
    moff = 0;
`ifdef DATA_MEM_MMIO_EN
    mmio = (a >= MMIO_BASE) && (a < MMIO_BASE + 12);
    moff = (a - MMIO_BASE) / 4;
`endif
    if (mmio) rd = (moff == 0) ? ref_cycle : (moff == 1) ? ref_tohost : ref_scratch;
    else if (ram) rd = ref_mem.exists(widx) ? ref_mem[widx] : 32'h0;
    else rd = 32'h0;
    exp_q.push_back(rd);
    legal = strb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    fault = rw && ((strb != 0 && !legal) || (!ram && !mmio) ||
                   (mmio && moff == 1 && strb != 0 && strb != 4'hF));
    if (fault) begin
      if (!ref_err) begin
        ref_err      = 1'b1;
        ref_err_addr = addr;
      end
    end else if (rw && strb != 0) begin
      if (mmio) begin
        if (moff == 1) begin
          ref_halt   = 1'b1;
          ref_tohost = data;
        end else if (moff == 2) begin
          ref_scratch = merge(ref_scratch, data, strb);
        end
      end else begin
        ref_mem[widx] = merge(ref_mem.exists(widx) ? ref_mem[widx] : 32'h0, data, strb);
      end
    end
    ref_cycle = ref_cycle + 32'd1;
  endtask

  // ---------------- driver ----------------
  task automatic do_cycle(input logic rw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] exp);
    i_data_rw        = rw;
    i_data_address   = addr;
    i_data           = data;
    i_data_rw_strobe = strb;
    model_access(rw, addr, data, strb);
    @(posedge i_clock);
    #1;
    exp = exp_q.pop_front();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] exp;
    do_reset(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", o_data); end
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", o_error); end
    n_checks++; if (o_error_address !== 32'h0) begin n_fail++; $display("FAIL reset_err_addr: got %h expected 0", o_error_address); end
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL reset_halt: got %b expected 0", o_halt); end
    n_checks++; if (o_tohost !== 32'h0) begin n_fail++; $display("FAIL reset_tohost: got %h expected 0", o_tohost); end
    do_cycle(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, exp);
    // Write attempted while reset is held must not reach the array.
    do_reset(1'b1, 32'h0, 32'h1234_5678, 4'hF);
    do_cycle(1'b0, 32'h0, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL ram_kept_over_reset: got %h expected %h", o_data, exp); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] exp;
    for (int i = 0; i < 17; i++) begin
      do_cycle(1'b1, (i == 16) ? 32'hFFC : 32'(i * 4), $urandom, 4'hF, exp);
    end
    do_cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, exp);
    do_cycle(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, exp);
    do_cycle(1'b0, 32'h10, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL lane_merge: got %h expected %h", o_data, exp); end
    n_checks++; if (o_data !== 32'hDEAD_BEAA) begin n_fail++; $display("FAIL lane_merge_const: got %h expected deadbeaa", o_data); end
    for (int k = 0; k < 7; k++) begin
      do_cycle(1'b1, 32'h14 | 32'($urandom_range(0, 3)), $urandom, legal_list[k], exp);
      do_cycle(1'b0, 32'h14, 32'h0, 4'h0, exp);
      n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL lane_strobe_%0d: got %h expected %h", k, o_data, exp); end
    end
    do_cycle(1'b1, 32'hFFC, 32'h5A5A_0001, 4'hF, exp);
    do_cycle(1'b0, 32'hFFC, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== 32'h5A5A_0001) begin n_fail++; $display("FAIL last_word: got %h expected 5a5a0001", o_data); end
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL last_word_err: got %b expected 0", o_error); end
  endtask

  task automatic test_read_during_write();
    logic [31:0] exp;
    do_cycle(1'b1, 32'h20, 32'h2222_2222, 4'hF, exp);
    do_cycle(1'b1, 32'h20, 32'h1111_1111, 4'hF, exp);
    n_checks++; if (o_data !== 32'h2222_2222) begin n_fail++; $display("FAIL rdw_old: got %h expected 22222222", o_data); end
    do_cycle(1'b0, 32'h20, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== 32'h1111_1111) begin n_fail++; $display("FAIL rdw_new: got %h expected 11111111", o_data); end
  endtask

  task automatic test_miss_read();
    logic [31:0] exp;
    do_cycle(1'b0, 32'h2000, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== 32'h0) begin n_fail++; $display("FAIL miss_data: got %h expected 0", o_data); end
    do_cycle(1'b0, 32'h1000, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL miss_edge: got %h expected %h", o_data, exp); end
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL miss_no_fault: got %b expected 0", o_error); end
  endtask

  task automatic test_faults();
    logic [31:0] exp;
    do_cycle(1'b1, 32'h30, 32'h0BAD_F00D, 4'hF, exp);
    do_cycle(1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, exp);
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL zero_strobe: got %b expected 0", o_error); end
    do_cycle(1'b1, 32'h30, 32'hFFFF_FFFF, 4'b0101, exp);
    n_checks++; if (o_error !== 1'b1) begin n_fail++; $display("FAIL bad_strobe_err: got %b expected 1", o_error); end
    do_cycle(1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, exp);
    n_checks++; if (o_error_address !== 32'h30) begin n_fail++; $display("FAIL first_fault_kept: got %h expected 30", o_error_address); end
    do_cycle(1'b0, 32'h30, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL fault_no_write: got %h expected 0badf00d", o_data); end
    do_reset(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if (o_error !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b expected 0", o_error); end
  endtask

  task automatic test_mmio();
    logic [31:0] exp;
    logic [31:0] c0;
    logic [31:0] c1;
    do_cycle(1'b0, 32'(MMIO_BASE), 32'h0, 4'h0, exp);
    c0 = o_data;
    n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL cycle_rd0: got %h expected %h", o_data, exp); end
    repeat (4) do_cycle(1'b0, 32'h0, 32'h0, 4'h0, exp);
    do_cycle(1'b0, 32'(MMIO_BASE), 32'h0, 4'h0, exp);
    c1 = o_data;
    n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL cycle_rd1: got %h expected %h", o_data, exp); end
`ifdef DATA_MEM_MMIO_EN
    n_checks++; if (c1 - c0 !== 32'd5) begin n_fail++; $display("FAIL cycle_delta: got %0d expected 5", c1 - c0); end
`endif
    do_cycle(1'b1, 32'(MMIO_BASE), 32'h1234, 4'hF, exp);
    n_checks++; if (o_error !== ref_err) begin n_fail++; $display("FAIL cycle_write_err: got %b expected %b", o_error, ref_err); end
    do_cycle(1'b1, 32'(MMIO_BASE) + 32'h8, 32'hA5A5_A5A5, 4'hF, exp);
    do_cycle(1'b1, 32'(MMIO_BASE) + 32'h8, 32'h0000_3C00, 4'b0010, exp);
    do_cycle(1'b0, 32'(MMIO_BASE) + 32'h8, 32'h0, 4'h0, exp);
    n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL scratch_rd: got %h expected %h", o_data, exp); end
    do_cycle(1'b1, 32'(MMIO_BASE) + 32'h4, 32'h1, 4'hF, exp);
    n_checks++; if (o_halt !== ref_halt) begin n_fail++; $display("FAIL halt: got %b expected %b", o_halt, ref_halt); end
    n_checks++; if (o_tohost !== ref_tohost) begin n_fail++; $display("FAIL tohost: got %h expected %h", o_tohost, ref_tohost); end
`ifdef DATA_MEM_MMIO_EN
    n_checks++; if (o_halt !== 1'b1 || o_tohost !== 32'h1) begin n_fail++; $display("FAIL tohost_const: got %b/%h expected 1/00000001", o_halt, o_tohost); end
`endif
    do_cycle(1'b1, 32'(MMIO_BASE) + 32'h4, 32'hFF, 4'b0011, exp);
    n_checks++; if (o_error !== ref_err) begin n_fail++; $display("FAIL tohost_partial_err: got %b expected %b", o_error, ref_err); end
    n_checks++; if (o_error_address !== ref_err_addr) begin n_fail++; $display("FAIL mmio_err_addr: got %h expected %h", o_error_address, ref_err_addr); end
    n_checks++; if (o_tohost !== ref_tohost) begin n_fail++; $display("FAIL tohost_hold: got %h expected %h", o_tohost, ref_tohost); end
    do_reset(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL halt_cleared: got %b expected 0", o_halt); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    logic [31:0] addr;
    logic [3:0]  strb;
    int          sel;
    int          idx;
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        idx  = $urandom_range(0, 16);
        addr = (idx == 16) ? 32'hFFC : 32'(idx * 4);
      end else if (sel == 6) addr = 32'h2000 + 32'($urandom_range(0, 255) * 4);
      else if (sel == 7) addr = 32'h1000;
      else addr = 32'(MMIO_BASE) + 32'($urandom_range(0, 3) * 4);
      addr = addr | 32'($urandom_range(0, 3));
      strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal_list[$urandom_range(0, 6)];
      do_cycle(1'($urandom_range(0, 1)), addr, $urandom, strb, exp);
      n_checks++; if (o_data !== exp) begin n_fail++; $display("FAIL rnd_data@%0d: got %h expected %h", n, o_data, exp); end
      n_checks++; if (o_error !== ref_err) begin n_fail++; $display("FAIL rnd_err@%0d: got %b expected %b", n, o_error, ref_err); end
      n_checks++; if (o_error_address !== ref_err_addr) begin n_fail++; $display("FAIL rnd_err_addr@%0d: got %h expected %h", n, o_error_address, ref_err_addr); end
      n_checks++; if (o_halt !== ref_halt) begin n_fail++; $display("FAIL rnd_halt@%0d: got %b expected %b", n, o_halt, ref_halt); end
      n_checks++; if (o_tohost !== ref_tohost) begin n_fail++; $display("FAIL rnd_tohost@%0d: got %h expected %h", n, o_tohost, ref_tohost); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    i_reset          = 1'b0;
    i_data_rw        = 1'b0;
    i_data_address   = 32'h0;
    i_data           = 32'h0;
    i_data_rw_strobe = 4'h0;
    test_reset();
    test_byte_lanes();
    test_read_during_write();
    test_miss_read();
    test_faults();
    test_mmio();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
